instr_fetch_stage: RTL and testbench

Fetch stage sitting directly downstream of the program counter. It accepts PC values, issues word reads to a synchronous instruction memory with 1-cycle read latency, and tags each returned instruction with its PC. It buffers fetched instructions in a small FIFO and presents them to decode through a valid/ready handshake. It also provides back-pressure to the PC and supports a flush from branch/jump resolution.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_skid_fifo.sv | 70 +++++++
 rtl/instr_fetch_stage.sv | 107 ++++++++++
 tb/tb_instr_fetch_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FIFO entry layout for the fetch stage.
// Entry = {fault, pc[31:0], instr[31:0]}, ENTRY_W bits wide.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int INSTR_LSB = 0;
   localparam int PC_LSB    = 32;
   localparam int FAULT_BIT = 64;
   localparam int ENTRY_W   = 65;

   typedef struct packed {
      logic        fault;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: synchronous FIFO, DEPTH x W, clear has priority.
// Ports: clka, rsta (async, high), clear, push, pop, wdata, rdata, count.
import fetch_pkg::*;

module fetch_skid_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = ENTRY_W
) (
   input  logic                       clka,
   input  logic                       rsta,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = nxt(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = nxt(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC -> sync imem (1-cycle) -> FIFO -> decode handshake.
// Ports: clka/rsta, pc_in/pc_valid/pc_ready, imem_en/addr/rdata, flush,
// if_valid/if_ready/if_instr/if_pc/if_fault. Macro: FETCH_ALIGN_CHECK_EN.
import fetch_pkg::*;

module instr_fetch_stage #(
   parameter int          ADDR_W     = 8,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic [31:0]       pc_in,
   input  logic              pc_valid,
   output logic              pc_ready,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              flush,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [31:0]       if_pc,
   output logic              if_fault
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OW    = CNT_W + 1;

   logic        inflight_q, inflight_d;
   logic        kill_q, kill_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        inflight_mis_q, inflight_mis_d;

   logic             accept, pop, push;
   logic [CNT_W-1:0] count;
   logic [OW-1:0]    occ;
   fetch_entry_t     wr_entry, head;

   assign pop    = if_valid & if_ready;
   assign accept = pc_valid & pc_ready;

   // Occupancy counts the in-flight read so its return always has a slot.
   assign occ = OW'(count) + OW'(inflight_q) - OW'(pop);

   assign pc_ready  = !rsta & !flush & (occ < OW'(FIFO_DEPTH));
   assign imem_en   = accept;
   assign imem_addr = rsta ? '0 : pc_in[ADDR_W+1:2];

   // A return landing in the flush cycle is dropped here; kill covers
   // the cycle after.
   assign push = inflight_q & !kill_q & !flush;

   always_comb begin
      inflight_d     = accept;
      inflight_pc_d  = accept ? pc_in : inflight_pc_q;
      inflight_mis_d = inflight_mis_q;
      kill_d         = flush & inflight_q;
      if (accept) begin
`ifdef FETCH_ALIGN_CHECK_EN
         inflight_mis_d = (pc_in[1:0] != 2'b00);
`else
         inflight_mis_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         inflight_q     <= 1'b0;
         kill_q         <= 1'b0;
         inflight_pc_q  <= '0;
         inflight_mis_q <= 1'b0;
      end else begin
         inflight_q     <= inflight_d;
         kill_q         <= kill_d;
         inflight_pc_q  <= inflight_pc_d;
         inflight_mis_q <= inflight_mis_d;
      end
   end

   always_comb begin
      wr_entry.fault = inflight_mis_q;
      wr_entry.pc    = inflight_pc_q;
      wr_entry.instr = inflight_mis_q ? NOP_INSTR : imem_rdata;
   end

   fetch_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clka  (clka),
      .rsta  (rsta),
      .clear (flush),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .count (count)
   );

   assign if_valid = (count != '0);
   assign if_instr = if_valid ? head.instr : NOP_INSTR;
   assign if_pc    = if_valid ? head.pc : 32'h0;
   assign if_fault = if_valid & head.fault;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed self-checking bench for instr_fetch_stage.
// Memory model returns 32'h1000_0000 + word address one cycle after imem_en.
module tb_instr_fetch_stage;

   logic        clka = 1'b0;
   logic        rsta;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        flush;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clka = ~clka;

   instr_fetch_stage dut (
      .clka       (clka),
      .rsta       (rsta),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_fault   (if_fault)
   );

   always @(posedge clka) begin
      if (imem_en) imem_rdata <= 32'h1000_0000 + {24'h0, imem_addr};
   end

   task automatic cyc();
      @(posedge clka);
      #1;
   endtask

   task automatic test_reset();
      rsta = 1'b1; pc_valid = 1'b1; pc_in = 32'h20; flush = 1'b0; if_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
      n_checks++; if (if_instr !== 32'h0) begin n_errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
      n_checks++; if (if_pc !== 32'h0) begin n_errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
      n_checks++; if (if_fault !== 1'b0) begin n_errors++; $display("FAIL rst_fault got %b exp 0", if_fault); end
      n_checks++; if (imem_en !== 1'b0) begin n_errors++; $display("FAIL rst_imem_en got %b exp 0", imem_en); end
      n_checks++; if (imem_addr !== 8'h0) begin n_errors++; $display("FAIL rst_imem_addr got %h exp 0", imem_addr); end
      n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL rst_pc_ready got %b exp 0", pc_ready); end
      cyc();
      rsta = 1'b0; pc_valid = 1'b0;
      cyc();
   endtask

   task automatic test_streaming();
      if_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         pc_valid = (k < 4);
         pc_in    = 32'(4 * k);
         @(negedge clka);
         if (k < 4) begin
            n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL stream_ready k=%0d got %b exp 1", k, pc_ready); end
            n_checks++; if (imem_addr !== 8'(k)) begin n_errors++; $display("FAIL stream_addr k=%0d got %h exp %h", k, imem_addr, 8'(k)); end
         end
         if (k >= 2 && k < 6) begin
            n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid k=%0d got %b exp 1", k, if_valid); end
            n_checks++; if (if_pc !== 32'(4 * (k - 2))) begin n_errors++; $display("FAIL stream_pc k=%0d got %h exp %h", k, if_pc, 32'(4 * (k - 2))); end
            n_checks++; if (if_instr !== 32'h1000_0000 + 32'(k - 2)) begin n_errors++; $display("FAIL stream_instr k=%0d got %h exp %h", k, if_instr, 32'h1000_0000 + 32'(k - 2)); end
         end else begin
            n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL stream_idle k=%0d got %b exp 0", k, if_valid); end
         end
         cyc();
      end
      pc_valid = 1'b0;
   endtask

   task automatic test_back_pressure();
      if_ready = 1'b0;
      pc_valid = 1'b1; pc_in = 32'h0;
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready0 got %b exp 1", pc_ready); end
      cyc();
      pc_in = 32'h4;
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready1 got %b exp 1", pc_ready); end
      cyc();
      pc_in = 32'h8;
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall0 got %b exp 0", pc_ready); end
      n_checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin n_errors++; $display("FAIL bp_head0 got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc); end
      cyc();
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall1 got %b exp 0", pc_ready); end
      n_checks++; if (imem_en !== 1'b0) begin n_errors++; $display("FAIL bp_no_en got %b exp 0", imem_en); end
      cyc();
      pc_valid = 1'b0; if_ready = 1'b1;
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got %b exp 1", pc_ready); end
      n_checks++; if (if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin n_errors++; $display("FAIL bp_pop0 got pc=%h instr=%h exp pc=0 instr=10000000", if_pc, if_instr); end
      cyc();
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h1000_0001) begin n_errors++; $display("FAIL bp_pop1 got v=%b pc=%h instr=%h exp v=1 pc=4 instr=10000001", if_valid, if_pc, if_instr); end
      cyc();
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty got %b exp 0", if_valid); end
      cyc();
   endtask

   task automatic test_flush();
      if_ready = 1'b0;
      pc_valid = 1'b1; pc_in = 32'h8;
      cyc();
      pc_in = 32'hC;
      cyc();
      flush = 1'b1; pc_in = 32'h40;
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready got %b exp 0", pc_ready); end
      n_checks++; if (imem_en !== 1'b0) begin n_errors++; $display("FAIL flush_en got %b exp 0", imem_en); end
      cyc();
      flush = 1'b0;
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL flush_cleared got v=%b pc=%h exp v=0", if_valid, if_pc); end
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL flush_redirect_ready got %b exp 1", pc_ready); end
      cyc();
      pc_valid = 1'b0;
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL flush_drop_c got v=%b pc=%h exp v=0", if_valid, if_pc); end
      cyc();
      if_ready = 1'b1;
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1000_0010) begin n_errors++; $display("FAIL flush_next got v=%b pc=%h instr=%h exp v=1 pc=40 instr=10000010", if_valid, if_pc, if_instr); end
      cyc();
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL flush_after got %b exp 0", if_valid); end
      cyc();
   endtask

   task automatic test_reset_mid();
      if_ready = 1'b0;
      pc_valid = 1'b1; pc_in = 32'h0;
      cyc();
      pc_in = 32'h4;
      cyc();
      pc_valid = 1'b0;
      cyc();
      n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre got %b exp 1", if_valid); end
      pc_valid = 1'b1; pc_in = 32'h8;
      #2 rsta = 1'b1;
      #1;
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got %b exp 0", if_valid); end
      n_checks++; if (if_instr !== 32'h0) begin n_errors++; $display("FAIL rstmid_instr got %h exp 0", if_instr); end
      n_checks++; if (imem_en !== 1'b0) begin n_errors++; $display("FAIL rstmid_en got %b exp 0", imem_en); end
      cyc();
      rsta = 1'b0; pc_in = 32'h0;
      @(negedge clka);
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready got %b exp 1", pc_ready); end
      cyc();
      pc_valid = 1'b0;
      cyc();
      if_ready = 1'b1;
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin n_errors++; $display("FAIL rstmid_first got v=%b pc=%h instr=%h exp v=1 pc=0 instr=10000000", if_valid, if_pc, if_instr); end
      cyc();
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_empty got %b exp 0", if_valid); end
      cyc();
   endtask

   task automatic test_wrap();
      if_ready = 1'b1;
      pc_valid = 1'b1; pc_in = 32'hFFFF_FFFC;
      @(negedge clka);
      n_checks++; if (imem_addr !== 8'hFF) begin n_errors++; $display("FAIL wrap_addr0 got %h exp ff", imem_addr); end
      cyc();
      pc_in = 32'h0;
      @(negedge clka);
      n_checks++; if (imem_addr !== 8'h00) begin n_errors++; $display("FAIL wrap_addr1 got %h exp 00", imem_addr); end
      cyc();
      pc_valid = 1'b0;
      @(negedge clka);
      n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h1000_00FF) begin n_errors++; $display("FAIL wrap_out0 got pc=%h instr=%h exp pc=fffffffc instr=100000ff", if_pc, if_instr); end
      cyc();
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin n_errors++; $display("FAIL wrap_out1 got v=%b pc=%h instr=%h exp v=1 pc=0 instr=10000000", if_valid, if_pc, if_instr); end
      cyc();
      cyc();
   endtask

   task automatic test_align();
      if_ready = 1'b1;
      pc_valid = 1'b1; pc_in = 32'h6;
      @(negedge clka);
      n_checks++; if (imem_addr !== 8'h01 || imem_en !== 1'b1) begin n_errors++; $display("FAIL align_issue got en=%b addr=%h exp en=1 addr=01", imem_en, imem_addr); end
      cyc();
      pc_valid = 1'b0;
      cyc();
      @(negedge clka);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h6) begin n_errors++; $display("FAIL align_pc got v=%b pc=%h exp v=1 pc=6", if_valid, if_pc); end
`ifdef FETCH_ALIGN_CHECK_EN
      n_checks++; if (if_fault !== 1'b1) begin n_errors++; $display("FAIL align_fault got %b exp 1", if_fault); end
      n_checks++; if (if_instr !== 32'h0) begin n_errors++; $display("FAIL align_instr got %h exp 0", if_instr); end
`else
      n_checks++; if (if_fault !== 1'b0) begin n_errors++; $display("FAIL align_fault got %b exp 0", if_fault); end
      n_checks++; if (if_instr !== 32'h1000_0001) begin n_errors++; $display("FAIL align_instr got %h exp 10000001", if_instr); end
`endif
      cyc();
      @(negedge clka);
      n_checks++; if (if_fault !== 1'b0 || if_valid !== 1'b0) begin n_errors++; $display("FAIL align_after got v=%b fault=%b exp 0 0", if_valid, if_fault); end
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      test_wrap();
      test_align();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
